match_sequencer: RTL and testbench
==================================

Name:
match_sequencer

Overview:
- Round/match controller for the fighter game. It sequences title, countdown, fight, KO and match-over phases.
- It gates player movement (freeze) and holds physics/health in reset between rounds.
- It keeps the round clock and round scores, and decides the match winner.
- Sits between the 20 Hz game-tick source and the physics, health, menu and 7-seg consumers. It replaces the ad-hoc winner/reset_cond logic in the top level.

Parameters:
- TICKS_PER_SEC, 20, game ticks per displayed second and per countdown digit.
- ROUND_SECONDS, 60, round clock start value (max 127).
- KO_TICKS, 40, ticks held in KO before the next decision.
- ROUNDS_TO_WIN, 2, round wins that end the match (max 3).
- MAX_ROUNDS, 5, hard cap on rounds played, draws included.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  single-clk-cycle pulse at 20 Hz; all state evaluation is qualified by tick
- start  in  1  start/confirm level (btnC, debounced upstream)
- health_1  in  9  player 1 health, 0 = KO
- health_2  in  9  player 2 health, 0 = KO
- game_state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 KO, 4 MATCH_OVER
- freeze  out  1  1 = movement/attack inputs ignored
- round_reset  out  1  level; physics and health held at initial values while high
- countdown  out  2  digit 3/2/1 during COUNTDOWN, else 0
- round_time  out  7  seconds remaining in the round
- p1_rounds  out  2  rounds won by player 1
- p2_rounds  out  2  rounds won by player 2
- round_count  out  3  rounds completed
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw (match result, valid in MATCH_OVER)

Behaviour:
- Reset (async, reset_n=0) values:
  - game_state=IDLE, freeze=1, round_reset=1, countdown=0
  - round_time=ROUND_SECONDS, p1_rounds=p2_rounds=0, round_count=0, winner=00
  - sub-tick counter=0, start_q=0
- Registers update only on clk edges with tick=1. Outputs are registered, so their latency is one tick-qualified edge.
- start_q <= start on each tick. start_rise = start & ~start_q.
- freeze = 1 in every state except FIGHT. round_reset = 1 in IDLE and COUNTDOWN only.
- IDLE:
  - On start_rise: clear rounds, round_count and winner; load sub_cnt=0, countdown=3.
  - Transition to COUNTDOWN.
- COUNTDOWN:
  - sub_cnt counts 0..TICKS_PER_SEC-1; at wrap, countdown decrements.
  - When countdown=1 and sub_cnt wraps: go to FIGHT with round_time=ROUND_SECONDS, sub_cnt=0, countdown=0.
  - Total duration is exactly 3*TICKS_PER_SEC ticks.
- FIGHT, checked each tick in this priority order:
  - (a) health_1=0 and health_2=0 -> round draw, no point.
  - (b) health_1=0 -> P2 point.
  - (c) health_2=0 -> P1 point.
  - (d) round_time=0 -> the higher health gets the point; equal health = draw, no point.
  - Any of (a)-(d) -> go to KO, round_count+1, sub_cnt=0. KO takes precedence over timeout on the same tick.
  - Otherwise sub_cnt advances. At wrap, round_time decrements, saturating at 0.
- Point increments saturate at ROUNDS_TO_WIN.
- KO:
  - Holds for KO_TICKS ticks (sub_cnt 0..KO_TICKS-1). On the final tick, decide:
    - p1_rounds=ROUNDS_TO_WIN -> MATCH_OVER, winner=01.
    - p2_rounds=ROUNDS_TO_WIN -> MATCH_OVER, winner=10.
    - round_count=MAX_ROUNDS -> MATCH_OVER, winner by round-score compare (tie = 11).
    - Otherwise -> COUNTDOWN with countdown=3.
- MATCH_OVER: all scores and winner held. start_rise -> IDLE, with winner cleared to 00 and scores retained until the next start.
- start is ignored outside IDLE and MATCH_OVER.
- reset_n asserted mid-round returns immediately to reset values, regardless of state or tick.
- Widths: sub_cnt sized for max(TICKS_PER_SEC, KO_TICKS); compare health as unsigned 9-bit.

Decomposition:
- Package match_pkg holds:
  - state encodings (IDLE..MATCH_OVER)
  - winner codes (W_NONE, W_P1, W_P2, W_DRAW)
  - 9-bit HEALTH_ZERO constant
- One sub-module, tick_timer: a loadable, tick-enabled up-counter with terminal-count output. It is instantiated once and reused for the countdown, round-clock seconds and KO hold.

Test Plan:
Use TICKS_PER_SEC=4, ROUND_SECONDS=3, KO_TICKS=2 for all tests.
- Reset, then start pulse -> COUNTDOWN on the next tick; countdown 3,2,1 each held 4 ticks; FIGHT after 12 ticks; round_reset falls and freeze falls on the FIGHT entry edge.
- In FIGHT, drive health_2=0 -> KO with p1_rounds=1 and round_count=1; after 2 ticks back to COUNTDOWN. A second P2 KO -> MATCH_OVER, winner=01.
- Hold both healths at 100/80 in FIGHT -> round_time goes 3,2,1,0 at 4-tick intervals; the next tick enters KO and P1 is awarded the point. At equal health, no point is awarded.
- Drive health_1=0 and health_2=0 on the same tick -> draw, no point. Repeat 5 draws -> MATCH_OVER after round 5, winner=11.
- Assert reset_n low during KO and during FIGHT -> outputs go to reset values asynchronously, before any tick.
- Pulse start during FIGHT -> no effect. Holding start high through MATCH_OVER entry produces no rise, so the state stays MATCH_OVER until start is released and pressed again.

Source files
------------

// File: rtl/match_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : match_pkg
//  Description : Shared encodings for the match sequencer: game phase
//                codes, match-winner codes, the health KO constant and a
//                saturating round-score increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package match_pkg;

    // Game phase encoding as seen on game_state
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_FIGHT      = 3'd2,
        S_KO         = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    // Match winner codes
    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    // A player with this health is knocked out
    localparam logic [8:0] HEALTH_ZERO = 9'd0;

    // Round score increment that stops at the match-winning count
    function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] cap);
        return (v >= cap) ? v : v + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : match_sequencer_if
//  Description : Bundles the match sequencer's tick/start/health inputs and
//                its phase, clock and score outputs.
//  Modports    : master - environment side (drives tick/start/health,
//                         observes status)
//                slave  - sequencer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface match_sequencer_if;

    logic       tick;          // 20 Hz single-cycle game tick
    logic       start;         // debounced start/confirm level
    logic [8:0] health_1;      // player 1 health, 0 = KO
    logic [8:0] health_2;      // player 2 health, 0 = KO
    logic [2:0] game_state;    // current phase
    logic       freeze;        // player inputs ignored
    logic       round_reset;   // physics/health held at initial values
    logic [1:0] countdown;     // 3/2/1 during COUNTDOWN, else 0
    logic [6:0] round_time;    // seconds remaining
    logic [1:0] p1_rounds;     // rounds won by player 1
    logic [1:0] p2_rounds;     // rounds won by player 2
    logic [2:0] round_count;   // rounds completed
    logic [1:0] winner;        // match result

    modport master (
        output tick, start, health_1, health_2,
        input  game_state, freeze, round_reset, countdown, round_time,
               p1_rounds, p2_rounds, round_count, winner
    );

    modport slave (
        input  tick, start, health_1, health_2,
        output game_state, freeze, round_reset, countdown, round_time,
               p1_rounds, p2_rounds, round_count, winner
    );

endinterface
`default_nettype wire

// File: rtl/match_sequencer_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer
//  Description : Loadable, tick-enabled up-counter. Counts 0..limit_i and
//                wraps to 0; tc_o flags the terminal value so the owner can
//                act on the same tick the counter wraps.
//  Ports       : clk, rst_n  - clock, asynchronous active-low reset
//                en_i        - tick qualifier; nothing changes without it
//                clr_i       - force count to 0 (priority over inc_i)
//                inc_i       - advance / wrap
//                limit_i     - terminal count value
//                tc_o        - count equals limit_i
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_timer #(
    parameter int WIDTH = 6
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en_i,
    input  wire logic             clr_i,
    input  wire logic             inc_i,
    input  wire logic [WIDTH-1:0] limit_i,
    output logic                  tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o = (count_q == limit_i);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : match_sequencer
//  Description : Round/match controller for the fighter game. Sequences
//                IDLE -> COUNTDOWN -> FIGHT -> KO -> (COUNTDOWN | MATCH_OVER),
//                gates player movement, holds physics/health in reset
//                between rounds, runs the round clock, keeps round scores
//                and decides the match winner. All state moves only on
//                clk edges qualified by the game tick.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                bus      - match_sequencer_if.slave (tick, start, health in;
//                           phase, freeze, round_reset, countdown,
//                           round_time, scores, round_count, winner out)
//  Revision    : 1.0 - initial release
// ============================================================================
module match_sequencer
    import match_pkg::*;
#(
    parameter int TICKS_PER_SEC = 20,
    parameter int ROUND_SECONDS = 60,
    parameter int KO_TICKS      = 40,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    match_sequencer_if.slave bus
);

    // One shared sub-tick counter serves countdown digits, round seconds and
    // the KO hold, so it is sized for the longer of the two periods.
    localparam int SUB_MAX = (TICKS_PER_SEC > KO_TICKS) ? TICKS_PER_SEC : KO_TICKS;
    localparam int SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;

    localparam logic [SUB_W-1:0] SEC_LAST = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0] KO_LAST  = SUB_W'(KO_TICKS - 1);
    localparam logic [6:0]       RT_INIT  = 7'(ROUND_SECONDS);
    localparam logic [1:0]       RTW      = 2'(ROUNDS_TO_WIN);
    localparam logic [2:0]       MAXR     = 3'(MAX_ROUNDS);

    state_t     state_q,     state_d;
    logic       freeze_q,    freeze_d;
    logic       rreset_q,    rreset_d;
    logic [1:0] countdown_q, countdown_d;
    logic [6:0] rtime_q,     rtime_d;
    logic [1:0] p1_q,        p1_d;
    logic [1:0] p2_q,        p2_d;
    logic [2:0] rcount_q,    rcount_d;
    logic [1:0] winner_q,    winner_d;
    logic       start_q;

    logic             start_rise;
    logic             tmr_clr;
    logic             tmr_inc;
    logic             tmr_tc;
    logic [SUB_W-1:0] tmr_limit;

    logic h1_ko, h2_ko, time_up;
    logic round_end, award_p1, award_p2;

    assign start_rise = bus.start & ~start_q;

    assign h1_ko   = (bus.health_1 == HEALTH_ZERO);
    assign h2_ko   = (bus.health_2 == HEALTH_ZERO);
    assign time_up = (rtime_q == 7'd0);

    // KO outranks timeout; a double KO or an equal-health timeout is a
    // drawn round and awards no point.
    assign round_end = h1_ko | h2_ko | time_up;
    assign award_p1  = ~h1_ko & (h2_ko | (time_up & (bus.health_1 > bus.health_2)));
    assign award_p2  = ~h2_ko & (h1_ko | (time_up & (bus.health_2 > bus.health_1)));

    // The KO hold uses its own period; every other phase counts seconds.
    assign tmr_limit = (state_q == S_KO) ? KO_LAST : SEC_LAST;

    tick_timer #(
        .WIDTH (SUB_W)
    ) u_tick_timer (
        .clk     (clk),
        .rst_n   (reset_n),
        .en_i    (bus.tick),
        .clr_i   (tmr_clr),
        .inc_i   (tmr_inc),
        .limit_i (tmr_limit),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        rtime_d     = rtime_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        rcount_d    = rcount_q;
        winner_d    = winner_q;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmr_clr = 1'b1;
                if (start_rise) begin
                    p1_d        = 2'd0;
                    p2_d        = 2'd0;
                    rcount_d    = 3'd0;
                    winner_d    = W_NONE;
                    countdown_d = 2'd3;
                    state_d     = S_COUNTDOWN;
                end
            end

            S_COUNTDOWN: begin
                tmr_inc = 1'b1;
                if (tmr_tc) begin
                    if (countdown_q == 2'd1) begin
                        countdown_d = 2'd0;
                        rtime_d     = RT_INIT;
                        state_d     = S_FIGHT;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end
            end

            S_FIGHT: begin
                if (round_end) begin
                    tmr_clr  = 1'b1;
                    rcount_d = rcount_q + 3'd1;
                    state_d  = S_KO;
                    if (award_p1) begin
                        p1_d = sat_inc(p1_q, RTW);
                    end
                    if (award_p2) begin
                        p2_d = sat_inc(p2_q, RTW);
                    end
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_tc && !time_up) begin
                        rtime_d = rtime_q - 7'd1;
                    end
                end
            end

            S_KO: begin
                tmr_inc = 1'b1;
                if (tmr_tc) begin
                    if (p1_q == RTW) begin
                        winner_d = W_P1;
                        state_d  = S_MATCH_OVER;
                    end else if (p2_q == RTW) begin
                        winner_d = W_P2;
                        state_d  = S_MATCH_OVER;
                    end else if (rcount_q == MAXR) begin
                        winner_d = (p1_q > p2_q) ? W_P1 :
                                   (p2_q > p1_q) ? W_P2 : W_DRAW;
                        state_d  = S_MATCH_OVER;
                    end else begin
                        countdown_d = 2'd3;
                        state_d     = S_COUNTDOWN;
                    end
                end
            end

            S_MATCH_OVER: begin
                tmr_clr = 1'b1;
                // Scores stay visible in IDLE until the next match starts.
                if (start_rise) begin
                    winner_d = W_NONE;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Gating outputs are registered alongside the state they describe.
        freeze_d = (state_d != S_FIGHT);
        rreset_d = (state_d == S_IDLE) || (state_d == S_COUNTDOWN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            freeze_q    <= 1'b1;
            rreset_q    <= 1'b1;
            countdown_q <= 2'd0;
            rtime_q     <= RT_INIT;
            p1_q        <= 2'd0;
            p2_q        <= 2'd0;
            rcount_q    <= 3'd0;
            winner_q    <= W_NONE;
            start_q     <= 1'b0;
        end else if (bus.tick) begin
            state_q     <= state_d;
            freeze_q    <= freeze_d;
            rreset_q    <= rreset_d;
            countdown_q <= countdown_d;
            rtime_q     <= rtime_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            rcount_q    <= rcount_d;
            winner_q    <= winner_d;
            start_q     <= bus.start;
        end
    end

    assign bus.game_state  = state_q;
    assign bus.freeze      = freeze_q;
    assign bus.round_reset = rreset_q;
    assign bus.countdown   = countdown_q;
    assign bus.round_time  = rtime_q;
    assign bus.p1_rounds   = p1_q;
    assign bus.p2_rounds   = p2_q;
    assign bus.round_count = rcount_q;
    assign bus.winner      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_match_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_sequencer
//  Description : Directed self-checking bench for match_sequencer. Each step
//                pushes the expected post-tick outputs to a scoreboard,
//                issues one game tick and pops/compares against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_match_sequencer;

    localparam int TPS  = 4;
    localparam int RS   = 3;
    localparam int KOT  = 2;
    localparam int RTW  = 2;
    localparam int MAXR = 5;

    localparam int ST_IDLE = 0;
    localparam int ST_CD   = 1;
    localparam int ST_FI   = 2;
    localparam int ST_KO   = 3;
    localparam int ST_MO   = 4;

    localparam int WN = 0;
    localparam int W1 = 1;
    localparam int W2 = 2;
    localparam int WD = 3;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    match_sequencer_if bus ();

    match_sequencer #(
        .TICKS_PER_SEC (TPS),
        .ROUND_SECONDS (RS),
        .KO_TICKS      (KOT),
        .ROUNDS_TO_WIN (RTW),
        .MAX_ROUNDS    (MAXR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int st;
        int cd;
        int rt;
        int p1;
        int p2;
        int rc;
        int win;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int st, input int cd, input int rt, input int p1,
                        input int p2, input int rc, input int win);
        exp_t e;
        e = '{st, cd, rt, p1, p2, rc, win};
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".state"},     {29'd0, bus.game_state},  32'(e.st));
            chk({tag, ".freeze"},    {31'd0, bus.freeze},      (e.st != ST_FI) ? 32'd1 : 32'd0);
            chk({tag, ".rreset"},    {31'd0, bus.round_reset},
                ((e.st == ST_IDLE) || (e.st == ST_CD)) ? 32'd1 : 32'd0);
            chk({tag, ".countdown"}, {30'd0, bus.countdown},   32'(e.cd));
            chk({tag, ".rtime"},     {25'd0, bus.round_time},  32'(e.rt));
            chk({tag, ".p1"},        {30'd0, bus.p1_rounds},   32'(e.p1));
            chk({tag, ".p2"},        {30'd0, bus.p2_rounds},   32'(e.p2));
            chk({tag, ".rcount"},    {29'd0, bus.round_count}, 32'(e.rc));
            chk({tag, ".winner"},    {30'd0, bus.winner},      32'(e.win));
        end
    endtask

    task automatic tick_once();
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic step(input string tag, input int st, input int cd, input int rt,
                        input int p1, input int p2, input int rc, input int win);
        push(st, cd, rt, p1, p2, rc, win);
        tick_once();
        check_pop(tag);
    endtask

    // 3 digits x TPS ticks; the last tick lands in FIGHT with a full clock.
    task automatic run_countdown(input string tag, input int rt0, input int p1,
                                 input int p2, input int rc);
        for (int k = 1; k <= 3 * TPS; k++) begin
            if (k < 3 * TPS) step(tag, ST_CD, 3 - k / TPS, rt0, p1, p2, rc, WN);
            else             step(tag, ST_FI, 0, RS, p1, p2, rc, WN);
        end
    endtask

    // Clock runs down to 0, then the following tick ends the round.
    task automatic run_timeout(input string tag, input int p1, input int p2, input int rc,
                               input int np1, input int np2);
        for (int k = 1; k <= TPS * RS; k++) begin
            step(tag, ST_FI, 0, RS - k / TPS, p1, p2, rc, WN);
        end
        step(tag, ST_KO, 0, 0, np1, np2, rc + 1, WN);
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        push(ST_IDLE, 0, RS, 0, 0, 0, WN);
        check_pop(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        bus.tick     = 1'b0;
        bus.start    = 1'b0;
        bus.health_1 = 9'd100;
        bus.health_2 = 9'd100;
        #23;
        push(ST_IDLE, 0, RS, 0, 0, 0, WN);
        check_pop("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // ---- Match 1: KO wins for P1 ----
        step("idle_wait", ST_IDLE, 0, RS, 0, 0, 0, WN);
        bus.start = 1'b1;
        step("start1", ST_CD, 3, RS, 0, 0, 0, WN);
        bus.start = 1'b0;
        run_countdown("cd1", RS, 0, 0, 0);
        step("fight1", ST_FI, 0, RS, 0, 0, 0, WN);
        bus.health_2 = 9'd0;
        step("ko_p2zero", ST_KO, 0, RS, 1, 0, 1, WN);
        bus.health_2 = 9'd100;
        step("ko_hold", ST_KO, 0, RS, 1, 0, 1, WN);
        step("ko_to_cd", ST_CD, 3, RS, 1, 0, 1, WN);
        run_countdown("cd2", RS, 1, 0, 1);
        bus.start = 1'b1;
        step("start_in_fight", ST_FI, 0, RS, 1, 0, 1, WN);
        bus.start = 1'b0;
        step("fight2", ST_FI, 0, RS, 1, 0, 1, WN);
        bus.health_2 = 9'd0;
        step("ko2", ST_KO, 0, RS, 2, 0, 2, WN);
        bus.health_2 = 9'd100;
        step("ko2_hold", ST_KO, 0, RS, 2, 0, 2, WN);
        step("match_p1", ST_MO, 0, RS, 2, 0, 2, W1);
        step("mo_hold", ST_MO, 0, RS, 2, 0, 2, W1);
        bus.start = 1'b1;
        step("mo_to_idle", ST_IDLE, 0, RS, 2, 0, 2, WN);
        bus.start = 1'b0;
        step("idle_keeps_scores", ST_IDLE, 0, RS, 2, 0, 2, WN);

        // ---- Match 2: timeouts; start held high throughout ----
        bus.health_1 = 9'd100;
        bus.health_2 = 9'd80;
        bus.start    = 1'b1;
        step("start2", ST_CD, 3, RS, 0, 0, 0, WN);
        run_countdown("cd3", RS, 0, 0, 0);
        run_timeout("to_p1", 0, 0, 0, 1, 0);
        step("to_p1_hold", ST_KO, 0, 0, 1, 0, 1, WN);
        step("to_p1_cd", ST_CD, 3, 0, 1, 0, 1, WN);
        bus.health_1 = 9'd90;
        bus.health_2 = 9'd90;
        run_countdown("cd4", 0, 1, 0, 1);
        run_timeout("to_equal", 1, 0, 1, 1, 0);
        step("to_eq_hold", ST_KO, 0, 0, 1, 0, 2, WN);
        step("to_eq_cd", ST_CD, 3, 0, 1, 0, 2, WN);
        bus.health_1 = 9'd50;
        bus.health_2 = 9'd120;
        run_countdown("cd5", 0, 1, 0, 2);
        run_timeout("to_p2", 1, 0, 2, 1, 1);
        step("to_p2_hold", ST_KO, 0, 0, 1, 1, 3, WN);
        step("to_p2_cd", ST_CD, 3, 0, 1, 1, 3, WN);
        bus.health_1 = 9'd100;
        bus.health_2 = 9'd80;
        run_countdown("cd6", 0, 1, 1, 3);
        run_timeout("to_p1b", 1, 1, 3, 2, 1);
        step("to_p1b_hold", ST_KO, 0, 0, 2, 1, 4, WN);
        step("mo_timeout", ST_MO, 0, 0, 2, 1, 4, W1);
        step("mo_start_held1", ST_MO, 0, 0, 2, 1, 4, W1);
        step("mo_start_held2", ST_MO, 0, 0, 2, 1, 4, W1);
        bus.start = 1'b0;
        step("mo_start_low", ST_MO, 0, 0, 2, 1, 4, W1);
        bus.start = 1'b1;
        step("mo_press", ST_IDLE, 0, 0, 2, 1, 4, WN);

        // ---- Match 3: five drawn rounds ----
        bus.start = 1'b0;
        step("idle3", ST_IDLE, 0, 0, 2, 1, 4, WN);
        bus.start = 1'b1;
        step("start3", ST_CD, 3, 0, 0, 0, 0, WN);
        bus.start = 1'b0;
        for (int r = 1; r <= MAXR; r++) begin
            run_countdown("cd_draw", (r == 1) ? 0 : RS, 0, 0, r - 1);
            bus.health_1 = 9'd0;
            bus.health_2 = 9'd0;
            step("double_ko", ST_KO, 0, RS, 0, 0, r, WN);
            bus.health_1 = 9'd100;
            bus.health_2 = 9'd100;
            step("draw_hold", ST_KO, 0, RS, 0, 0, r, WN);
            if (r < MAXR) step("draw_next", ST_CD, 3, RS, 0, 0, r, WN);
            else          step("draw_match", ST_MO, 0, RS, 0, 0, MAXR, WD);
        end
        bus.start = 1'b1;
        step("mo3_idle", ST_IDLE, 0, RS, 0, 0, MAXR, WN);
        bus.start = 1'b0;
        step("idle4", ST_IDLE, 0, RS, 0, 0, MAXR, WN);

        // ---- Asynchronous reset during FIGHT and during KO ----
        bus.start = 1'b1;
        step("start4", ST_CD, 3, RS, 0, 0, 0, WN);
        bus.start = 1'b0;
        run_countdown("cd_rst1", RS, 0, 0, 0);
        step("fight_rst", ST_FI, 0, RS, 0, 0, 0, WN);
        async_reset_check("async_rst_fight");
        step("after_rst1", ST_IDLE, 0, RS, 0, 0, 0, WN);
        bus.start = 1'b1;
        step("start5", ST_CD, 3, RS, 0, 0, 0, WN);
        bus.start = 1'b0;
        run_countdown("cd_rst2", RS, 0, 0, 0);
        bus.health_2 = 9'd0;
        step("ko_rst", ST_KO, 0, RS, 1, 0, 1, WN);
        bus.health_2 = 9'd100;
        async_reset_check("async_rst_ko");
        step("after_rst2", ST_IDLE, 0, RS, 0, 0, 0, WN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
